// File: rtl/vadd_ctrl_pkg.sv
// Shared types for the vector-add job controller.
//   state_t      : controller FSM encoding (IDLE, RUN, DRAIN, DONE)
//   skid_entry_t : layout of one skid-buffer entry at the default data width
//                  ({data, last}, last in bit 0). The top packs entries the
//                  same way for any C_DATA_WIDTH.
package vadd_ctrl_pkg;

  localparam int C_BEAT_W_DEF     = 16;
  localparam int C_DATA_WIDTH_DEF = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [C_DATA_WIDTH_DEF-1:0] data;
    logic                        last;
  } skid_entry_t;

endpackage

// File: rtl/vadd_skid_buf.sv
// Two-entry skid buffer with a registered output.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (flushes contents)
//   push, wdata    : write request and entry; ignored while full
//   full           : both entries occupied (pure function of the fill register)
//   pop            : consume the head entry; ignored while empty
//   avail, out     : head entry valid and its contents (straight from a register)
// Entry 0 is always the head, so `out` only changes on a pop or on a push into
// an empty buffer; a stalled head therefore holds still.
module vadd_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic         avail,
  output logic [W-1:0] out
);

  logic [1:0]   count;
  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign avail   = (count != 2'd0);
  assign out     = mem0;
  assign do_push = push & ~full;
  assign do_pop  = pop & avail;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) mem0 <= wdata;
          else               mem1 <= wdata;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem0  <= mem1;
          count <= count - 2'd1;
        end
        // Push and pop together: only reachable with one entry held (not full,
        // not empty), so the new entry replaces the head and occupancy stays 1.
        2'b11: begin
          mem0 <= wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vadd_job_ctrl.sv
// Job sequencer for the vector-add streaming kernel.
// Accepts a beat-count command, gates exactly that many source beats into the
// kernel, collects the same number of kernel output beats through a 2-entry
// skid buffer, marks the final output beat with dst_last and pulses done.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_beats    : job command (beat count, 0 allowed)
//   src_avail/src_ready/src_data     : source stream in
//   kin_avail/kin_ready/kin_data     : stream to kernel input
//   kout_avail/kout_ready/kout_data  : stream from kernel output
//   dst_avail/dst_ready/dst_data/dst_last : output stream to sink
//   done                             : one-cycle pulse at job completion
//   busy                             : job in progress (state != IDLE)
//   state_dbg                        : current FSM state for observation
// Handshake: every stream pair transfers a beat on a rising edge where both
// avail/valid and ready are high; the producer keeps avail and data stable
// until that transfer (src_avail is allowed to drop freely), and ready may be
// raised or lowered at any time.
module vadd_job_ctrl
  import vadd_ctrl_pkg::*;
#(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_BEAT_W     = C_BEAT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [C_BEAT_W-1:0]     cmd_beats,
  input  logic                    src_avail,
  output logic                    src_ready,
  input  logic [C_DATA_WIDTH-1:0] src_data,
  output logic                    kin_avail,
  input  logic                    kin_ready,
  output logic [C_DATA_WIDTH-1:0] kin_data,
  input  logic                    kout_avail,
  output logic                    kout_ready,
  input  logic [C_DATA_WIDTH-1:0] kout_data,
  output logic                    dst_avail,
  input  logic                    dst_ready,
  output logic [C_DATA_WIDTH-1:0] dst_data,
  output logic                    dst_last,
  output logic                    done,
  output logic                    busy,
  output state_t                  state_dbg
);

  state_t                state;
  logic [C_BEAT_W-1:0]   beats;
  logic [C_BEAT_W-1:0]   in_cnt;
  logic [C_BEAT_W-1:0]   out_cnt;

  logic                  in_run;
  logic                  out_active;
  logic                  in_fire;
  logic                  in_last;
  logic                  kout_fire;
  logic                  out_last;
  logic                  last_fire;

  logic                  skid_full;
  logic                  skid_avail;
  logic [C_DATA_WIDTH:0] skid_out;

  assign in_run     = (state == RUN);
  assign out_active = (state == RUN) || (state == DRAIN);

  // Input path: combinational pass-through while RUN, closed otherwise.
  assign kin_avail = in_run & src_avail;
  assign src_ready = in_run & kin_ready;
  assign kin_data  = src_data;
  assign in_fire   = in_run & src_avail & kin_ready;
  assign in_last   = (in_cnt == beats - C_BEAT_W'(1));

  // Output path: ready comes only from registered state (fill level, counters,
  // FSM), never from dst_ready, so the kernel's in_ready = out_ready loop is cut.
  assign kout_ready = out_active & ~skid_full & (out_cnt < beats);
  assign kout_fire  = kout_avail & kout_ready;
  assign out_last   = (out_cnt == beats - C_BEAT_W'(1));

  vadd_skid_buf #(
    .W (C_DATA_WIDTH + 1)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (kout_fire),
    .wdata ({kout_data, out_last}),
    .full  (skid_full),
    .pop   (dst_ready),
    .avail (skid_avail),
    .out   (skid_out)
  );

  assign dst_avail = skid_avail;
  assign dst_data  = skid_out[C_DATA_WIDTH:1];
  assign dst_last  = skid_avail & skid_out[0];
  assign last_fire = dst_avail & dst_ready & dst_last;

  // Status decoded from the state register; cmd_ready is also held low while
  // reset is asserted.
  assign cmd_ready = (state == IDLE) & ~reset;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beats   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (kout_fire) out_cnt <= out_cnt + C_BEAT_W'(1);
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            beats   <= cmd_beats;
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= (cmd_beats == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            in_cnt <= in_cnt + C_BEAT_W'(1);
            if (in_last) state <= last_fire ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          if (last_fire) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vadd_job_ctrl.sv
// Bench for vadd_job_ctrl. The bench plays host, source, pass-through kernel
// and sink. Every accepted source beat is pushed (with its expected last flag)
// into a queue; every accepted dst beat is popped and compared.
module tb_vadd_job_ctrl;
  import vadd_ctrl_pkg::*;

  localparam int DW = 64;
  localparam int BW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [BW-1:0] cmd_beats = '0;
  logic          src_avail;
  logic          src_ready;
  logic [DW-1:0] src_data;
  logic          kin_avail;
  logic          kin_ready;
  logic [DW-1:0] kin_data;
  logic          kout_avail;
  logic          kout_ready;
  logic [DW-1:0] kout_data;
  logic          dst_avail;
  logic          dst_ready;
  logic [DW-1:0] dst_data;
  logic          dst_last;
  logic          done;
  logic          busy;
  state_t        state_dbg;

  vadd_job_ctrl #(
    .C_DATA_WIDTH (DW),
    .C_BEAT_W     (BW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_beats  (cmd_beats),
    .src_avail  (src_avail),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .kin_avail  (kin_avail),
    .kin_ready  (kin_ready),
    .kin_data   (kin_data),
    .kout_avail (kout_avail),
    .kout_ready (kout_ready),
    .kout_data  (kout_data),
    .dst_avail  (dst_avail),
    .dst_ready  (dst_ready),
    .dst_data   (dst_data),
    .dst_last   (dst_last),
    .done       (done),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Combinational pass-through kernel.
  assign kout_avail = kin_avail;
  assign kin_ready  = kout_ready;
  assign kout_data  = kin_data;

  // ---------------- check / counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- source driver ----------------
  int src_offered = 0;  // written by main
  int src_taken   = 0;  // written by source process
  bit src_rand    = 0;

  initial begin
    bit fire;
    src_avail = 1'b0;
    src_data  = {$urandom, $urandom};
    forever begin
      @(negedge clk);
      fire = src_avail && src_ready && !reset;
      @(posedge clk);
      #1;
      if (fire) begin
        src_taken++;
        src_data = {$urandom, $urandom};
      end
      src_avail = ((src_offered - src_taken) > 0) &&
                  (!src_rand || ($urandom_range(0, 1) == 1));
    end
  end

  // ---------------- sink driver ----------------
  int dst_mode = 0;  // 0 always ready, 1 toggle, 2 random

  initial begin
    dst_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (dst_mode)
        0:       dst_ready = 1'b1;
        1:       dst_ready = ~dst_ready;
        default: dst_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW:0] exp_q[$];
  int cur_beats = 0, in_idx = 0, occ = 0;
  int acc_cyc = 0, done_cyc = 0;
  int n_done = 0, n_out = 0, n_last = 0, n_in = 0;
  int n_src_ready_cyc = 0, n_dst_avail_cyc = 0;
  bit          hold_prev = 0;
  logic [DW:0] held_val;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      occ       = 0;
      in_idx    = 0;
      hold_prev = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        cur_beats = int'(cmd_beats);
        in_idx    = 0;
        acc_cyc   = cyc;
      end
      if (src_ready) n_src_ready_cyc++;
      if (dst_avail) n_dst_avail_cyc++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (kout_ready) check("kout_ready_while_full", (occ < 2) ? 1 : 0, 1);
      if (hold_prev) begin
        check("dst_hold_avail", dst_avail, 1);
        check("dst_hold_data", {dst_data, dst_last}, held_val);
      end
      if (src_avail && src_ready) begin
        check("src_overrun", (in_idx < cur_beats) ? 1 : 0, 1);
        exp_q.push_back({src_data, (in_idx == cur_beats - 1)});
        in_idx++;
        n_in++;
      end
      if (kout_avail && kout_ready) occ++;
      if (dst_avail && dst_ready) begin
        if (exp_q.size() == 0) check("dst_unexpected_beat", 1, 0);
        else check("dst_beat", {dst_data, dst_last}, exp_q.pop_front());
        occ--;
        n_out++;
        if (dst_last) n_last++;
      end
      hold_prev = dst_avail && !dst_ready;
      held_val  = {dst_data, dst_last};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int beats);
    int t = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_beats = beats[BW-1:0];
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      t++;
      if (t > 300) begin
        check("cmd_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (n_done <= n0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", (n_done > n0) ? 1 : 0, 1);
  endtask

  task automatic idle_outputs(input string tag);
    check(tag, {src_ready, kin_avail, kout_ready, dst_avail, dst_last, done, busy}, 0);
  endtask

  // ---------------- main sequence ----------------
  int d0, o0, l0, i0, s0, a0, b, first_acc;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    idle_outputs("reset_outputs");
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_state", state_dbg, IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    // Basic job: 4 beats, no stalls
    d0 = n_done; o0 = n_out; l0 = n_last;
    src_offered = src_taken + 4;
    send_cmd(4);
    wait_done(d0);
    check("basic_done_cycle", done_cyc - acc_cyc, 6);
    repeat (3) @(negedge clk);
    check("basic_done_count", n_done - d0, 1);
    check("basic_out_count", n_out - o0, 4);
    check("basic_last_count", n_last - l0, 1);
    check("basic_busy_after", busy, 0);
    check("basic_queue_empty", exp_q.size(), 0);

    // Zero-length job with source beats waiting: nothing may move
    d0 = n_done; s0 = n_src_ready_cyc; a0 = n_dst_avail_cyc;
    src_offered = src_taken + 2;
    send_cmd(0);
    wait_done(d0);
    check("zero_done_cycle", done_cyc - acc_cyc, 1);
    repeat (3) @(negedge clk);
    check("zero_src_ready_cycles", n_src_ready_cyc - s0, 0);
    check("zero_dst_avail_cycles", n_dst_avail_cyc - a0, 0);
    check("zero_src_pending", src_offered - src_taken, 2);
    src_offered = src_taken;

    // Sink backpressure: 8 beats, dst_ready toggling
    d0 = n_done; o0 = n_out; l0 = n_last;
    dst_mode = 1;
    src_offered = src_taken + 8;
    send_cmd(8);
    wait_done(d0);
    repeat (2) @(negedge clk);
    check("bp_out_count", n_out - o0, 8);
    check("bp_last_count", n_last - l0, 1);
    check("bp_queue_empty", exp_q.size(), 0);
    dst_mode = 0;

    // Overrun guard: 10 offered, 6 consumed
    d0 = n_done; i0 = n_in;
    src_offered = src_taken + 10;
    send_cmd(6);
    wait_done(d0);
    repeat (3) @(negedge clk);
    check("overrun_in_count", n_in - i0, 6);
    check("overrun_pending", src_offered - src_taken, 4);
    check("overrun_src_held", {src_avail, src_ready}, 2'b10);
    src_offered = src_taken;

    // Reset mid-job after 5 output beats
    d0 = n_done; o0 = n_out;
    src_offered = src_taken + 16;
    send_cmd(16);
    begin
      int t = 0;
      while ((n_out - o0) < 5 && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("midjob_out_timeout", ((n_out - o0) >= 5) ? 1 : 0, 1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle_outputs("midjob_reset_outputs");
    check("midjob_reset_cmd_ready", cmd_ready, 0);
    src_offered = src_taken;
    @(posedge clk);
    #1;
    reset = 1'b0;
    src_offered = src_taken;
    @(negedge clk);
    check("midjob_cmd_ready", cmd_ready, 1);
    check("midjob_no_done", n_done - d0, 0);
    d0 = n_done; o0 = n_out; l0 = n_last;
    src_offered = src_taken + 2;
    send_cmd(2);
    wait_done(d0);
    check("post_reset_done_cycle", done_cyc - acc_cyc, 4);
    repeat (2) @(negedge clk);
    check("post_reset_out_count", n_out - o0, 2);
    check("post_reset_last_count", n_last - l0, 1);

    // Back-to-back jobs: 3 then 2
    d0 = n_done; o0 = n_out; l0 = n_last;
    src_offered = src_taken + 5;
    send_cmd(3);
    first_acc = acc_cyc;
    send_cmd(2);
    check("b2b_second_after_done", (acc_cyc > done_cyc && done_cyc > first_acc) ? 1 : 0, 1);
    check("b2b_accept_gap", acc_cyc - done_cyc, 1);
    wait_done(d0 + 1);
    repeat (2) @(negedge clk);
    check("b2b_out_count", n_out - o0, 5);
    check("b2b_last_count", n_last - l0, 2);

    // Random stalls on both sides
    src_rand = 1;
    dst_mode = 2;
    for (int j = 0; j < 4; j++) begin
      b  = int'($urandom_range(1, 12));
      d0 = n_done; o0 = n_out;
      src_offered = src_taken + b;
      send_cmd(b);
      wait_done(d0);
      repeat (2) @(negedge clk);
      check("rand_out_count", n_out - o0, b);
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vadd_job_ctrl.md
# vadd_job_ctrl

Job sequencer for the vector-add streaming kernel. It accepts a command holding a beat count, gates exactly that many beats from the source stream into the kernel, and counts the same number of beats back out. It buffers kernel output through a 2-entry skid buffer, tags the final beat with `dst_last`, and pulses `done` when the job completes. It sits between the host/DMA stream shell and the kernel, so the kernel itself stays purely combinational.

## Interface
Parameters:
- `C_DATA_WIDTH`, 512: stream data width; must match the kernel.
- `C_BEAT_W`, 16: width of the beat-count field; maximum job is 2^C_BEAT_W−1 beats.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `cmd_valid`, in, 1: job command present.
- `cmd_ready`, out, 1: controller accepts a command.
- `cmd_beats`, in, C_BEAT_W: number of beats in the job.
- `src_avail`, in, 1: source beat valid.
- `src_ready`, out, 1: source beat accepted.
- `src_data`, in, C_DATA_WIDTH: source beat payload.
- `kin_avail`, out, 1: drives kernel `in_avail`.
- `kin_ready`, in, 1: from kernel `in_ready`.
- `kin_data`, out, C_DATA_WIDTH: drives kernel `in_data`.
- `kout_avail`, in, 1: from kernel `out_avail`.
- `kout_ready`, out, 1: drives kernel `out_ready`.
- `kout_data`, in, C_DATA_WIDTH: from kernel `out_data`.
- `dst_avail`, out, 1: output beat valid.
- `dst_ready`, in, 1: sink accepts the output beat.
- `dst_data`, out, C_DATA_WIDTH: output beat payload.
- `dst_last`, out, 1: set on the final beat of the job.
- `done`, out, 1: one-cycle pulse at job completion.
- `busy`, out, 1: a job is in progress (`state != IDLE`).

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `cmd_ready=1`.
  - On `cmd_valid` with `cmd_beats != 0`: latch the count, clear `in_cnt` and `out_cnt`, go to RUN.
  - On `cmd_valid` with `cmd_beats == 0`: accept the command and go directly to DONE. No data moves.
- **RUN**
  - Forward the source to the kernel: `kin_avail = src_avail`, `src_ready = kin_ready`, `kin_data = src_data`.
  - `in_cnt` increments on each `src_avail & kin_ready`.
  - When the beat that makes `in_cnt == beats` is transferred, go to DRAIN.
- **DRAIN**
  - `kin_avail=0`, `src_ready=0`.
  - Stay until the `dst_last` beat is accepted (`dst_avail & dst_ready & dst_last`), then go to DONE.
  - If that acceptance happens in RUN in the same cycle as the final input beat, go straight to DONE.
- **DONE**
  - `done=1` for exactly one cycle, `cmd_ready=0`, then go to IDLE.
- **Output side (RUN and DRAIN only)**
  - `kout_ready = !skid_full & (out_cnt < beats)`.
  - `out_cnt` increments on each `kout_avail & kout_ready`.
  - The entry written when `out_cnt == beats−1` gets `last=1`.
- **Outside a job:** in IDLE and DONE, `kout_ready=0` and `kin_avail=0`, and any stray kernel output is held off. Beats above the job count are never forwarded.
- **Counters** are C_BEAT_W bits unsigned and never wrap, because they are bounded by `beats`.

## Timing
- **Reset values:**
  - State is IDLE; counters and skid buffer are empty.
  - `cmd_ready=0` while `reset` is high; it reads 1 the first cycle after reset is released.
  - `src_ready`, `kin_avail`, `kout_ready`, `dst_avail`, `dst_last`, `done`, `busy` are all 0.
  - `dst_data` is don't-care while `dst_avail=0`.
- **Input path:** zero latency. The source-to-kernel path is combinational in RUN.
- **Output path:** kernel-to-`dst` latency is 1 cycle through the skid buffer. `dst_*` are driven from registers.
- **Skid buffer:**
  - `kout_ready` depends only on the registered fill state, so there is no combinational path `dst_ready` → `kout_ready`. This breaks the `in_ready = out_ready` loop through the kernel.
  - With `dst_ready` held high, throughput is 1 beat/cycle.
  - Simultaneous push and pop while holding one entry keeps occupancy at one.
- **Stream rules:**
  - Once asserted, `dst_avail` and `dst_data` stay stable until accepted.
  - `src_avail` may drop at any time without loss.
- **Job timing:** a minimal N-beat job with no stalls asserts `done` at cycle N+2 after command acceptance.
- **Reset mid-job:** the job is dropped on the next edge. The skid buffer is flushed, no `done` is issued, and `cmd_ready` reads 1 the first cycle after reset is released.

## Structure
- **Package `vadd_ctrl_pkg`:**
  - `state_t` enum {IDLE, RUN, DRAIN, DONE}.
  - Default `C_BEAT_W` localparam.
  - `skid_entry_t` struct {data, last}.
- **Sub-module `vadd_skid_buf`:** 2-entry, parameterised on width. Has `push/full`, `pop/avail` and an `out` port. Instantiated once.
- **Top level:** FSM and counters live in `vadd_job_ctrl`. The kernel is instantiated by the parent, not inside this block.

## Test plan
- **Basic job:** `cmd_beats=4`, `src_avail` always high, `dst_ready` always high → 4 beats out with data identical to the source, `dst_last` on beat 4 only, `done` pulses once at cycle 6, `busy` is low afterward.
- **Zero-length job:** `cmd_beats=0` → `done` pulses the cycle after acceptance; `src_ready` and `dst_avail` never assert.
- **Sink backpressure:** `cmd_beats=8`, `dst_ready` toggling 1/0 → all 8 beats in order with no drops or duplicates; `kout_ready` never high while the buffer is full; `dst_data` stable during stalls.
- **Overrun guard:** source offers 10 beats with `cmd_beats=6` → exactly 6 beats consumed, `src_ready=0` from the 7th beat on, and the remaining 4 are still pending after `done`.
- **Reset mid-job:** `cmd_beats=16`, assert `reset` after 5 output beats → all outputs at reset values the next cycle, no `done`; a new job with `cmd_beats=2` then completes correctly.
- **Back-to-back jobs:** `cmd_beats=3` immediately followed by `cmd_beats=2` → the second command is accepted only after `done`; `dst_last` is set on beats 3 and 5 of the combined stream.
